parallel_tone_source: RTL and testbench

Parametrised L-lane stimulus generator that replaces the fixed 3-lane sine table plus free-running address counter used to drive the reduced-complexity parallel FIR filters. Each cycle it produces one vector of `LANES` consecutive samples of a phase-accumulated waveform, selected from one of four modes: sine, ramp, impulse or DC. Output uses a valid/ready handshake with stall support and an optional burst length. It sits between the test bench or top level and any `FIR_Filter_L*_Top` data inputs.

---
 rtl/parallel_tone_source.sv | 188 ++++++++++++++++++
 tb/tb_parallel_tone_source.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_tone_source.sv
// parallel_tone_source: L-lane phase-accumulated stimulus generator.
// Emits LANES consecutive samples per vector over a valid/ready handshake.
module parallel_tone_source #(
    parameter int LANES       = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 9,
    parameter int PHASE_WIDTH = 24,
    parameter     SINE_FILE   = "sine.hex"
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic [1:0]                    mode,
    input  logic [PHASE_WIDTH-1:0]        phase_inc,
    input  logic [3:0]                    gain_shift,
    input  logic [15:0]                   burst_len,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [LANES*DATA_WIDTH-1:0]   data_out,
    output logic                          busy,
    output logic [31:0]                   vec_count
);

    localparam int  DW  = DATA_WIDTH;
    localparam int  PW  = PHASE_WIDTH;
    localparam int  AW  = ADDR_WIDTH;
    localparam int  VW  = LANES * DW;
    localparam int  TBL = 1 << AW;
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = real'((2 ** (DW - 1)) - 1);

    localparam logic [1:0] M_SINE    = 2'd0;
    localparam logic [1:0] M_RAMP    = 2'd1;
    localparam logic [1:0] M_IMPULSE = 2'd2;

    localparam logic signed [DW-1:0] PEAK = {1'b0, {(DW - 1){1'b1}}};

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      phi_q, phi_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [PW-1:0]      inc_q, inc_d;
    logic [3:0]         gain_q, gain_d;
    logic [15:0]        burst_q, burst_d;
    logic               out_valid_q, out_valid_d;
    logic [VW-1:0]      data_q, data_d;
    logic               busy_q, busy_d;
    logic [31:0]        vec_count_q, vec_count_d;

    logic [VW-1:0]      lanes_vec;
    logic               load;
    logic               accept;

    // The sine table is built at elaboration from the same formula the
    // image file encodes, so no external file is needed to simulate.
    logic signed [DW-1:0] sine_lut [TBL];

    for (genvar g = 0; g < TBL; g++) begin : g_lut
        localparam real ANG = 2.0 * PI * real'(g) / real'(TBL);
        localparam real VR  = AMP * $sin(ANG);
        localparam int  VI  = (VR >= 0.0) ? $rtoi(VR + 0.5)
                                          : -$rtoi(0.5 - VR);
        assign sine_lut[g] = DW'(VI);
    end

    // Table name kept for drop-in compatibility; contents are computed.
    if (SINE_FILE == "") begin : g_unnamed_table
    end

    // Lane samples for the current phase, shaped by mode and gain.
    always_comb begin
        logic [PW-1:0]        lane_ph;
        logic signed [DW-1:0] raw;
        int                   shamt;
        lanes_vec = '0;
        lane_ph   = phi_q;
        raw       = '0;
        shamt     = (int'(gain_q) >= DW) ? DW - 1 : int'(gain_q);
        for (int k = 0; k < LANES; k++) begin
            unique case (mode_q)
                M_SINE:    raw = sine_lut[lane_ph[PW-1 -: AW]];
                M_RAMP:    raw = signed'(lane_ph[PW-1 -: DW]);
                M_IMPULSE: raw = (k == 0 && cnt_q == '0) ? PEAK : '0;
                default:   raw = PEAK;
            endcase
            lanes_vec[k*DW +: DW] = raw >>> shamt;
            lane_ph = lane_ph + inc_q;
        end
    end

    // Next-state, load and handshake bookkeeping.
    always_comb begin
        state_d     = state_q;
        phi_d       = phi_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        inc_d       = inc_q;
        gain_d      = gain_q;
        burst_d     = burst_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        vec_count_d = vec_count_q;
        load        = 1'b0;
        accept      = out_valid_q && out_ready;

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop && !out_valid_q) begin
                    state_d     = S_RUN;
                    mode_d      = mode;
                    inc_d       = phase_inc;
                    gain_d      = gain_shift;
                    burst_d     = burst_len;
                    phi_d       = '0;
                    cnt_d       = '0;
                    vec_count_d = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!out_valid_q || out_ready) begin
                    load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            phi_d       = phi_q + PW'(LANES) * inc_q;
            cnt_d       = cnt_q + 16'd1;
            out_valid_d = 1'b1;
            data_d      = lanes_vec;
            if (burst_q != '0 && cnt_q + 16'd1 == burst_q) begin
                state_d = S_IDLE;
            end
        end else if (accept) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            vec_count_d = vec_count_q + 32'd1;
        end

        busy_d = (state_d == S_RUN) || out_valid_d;
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            phi_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            inc_q       <= '0;
            gain_q      <= '0;
            burst_q     <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            phi_q       <= phi_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            inc_q       <= inc_d;
            gain_q      <= gain_d;
            burst_q     <= burst_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            vec_count_q <= vec_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign busy      = busy_q;
    assign vec_count = vec_count_q;

endmodule

// File: tb/tb_parallel_tone_source.sv
// tb_parallel_tone_source: randomized and directed checks against a
// sample-index reference model of the tone generator.
module tb_parallel_tone_source;

    localparam int  LANES = 3;
    localparam int  DW    = 16;
    localparam int  AW    = 9;
    localparam int  PW    = 24;
    localparam int  VW    = LANES * DW;
    localparam real PI    = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [1:0]      mode = '0;
    logic [PW-1:0]   phase_inc = '0;
    logic [3:0]      gain_shift = '0;
    logic [15:0]     burst_len = '0;
    logic            out_ready = 1'b0;
    logic            out_valid;
    logic [VW-1:0]   data_out;
    logic            busy;
    logic [31:0]     vec_count;

    parallel_tone_source #(
        .LANES      (LANES),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .PHASE_WIDTH(PW),
        .SINE_FILE  ("sine.hex")
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .phase_inc  (phase_inc),
        .gain_shift (gain_shift),
        .burst_len  (burst_len),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .data_out   (data_out),
        .busy       (busy),
        .vec_count  (vec_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int acc      = 0;
    int c_mode;
    longint c_inc;
    int c_gsh;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Vector n of a run: lane k is sample number n*LANES+k.
    function automatic logic [VW-1:0] exp_vec(input int n);
        logic [VW-1:0] v;
        longint        ph;
        int            s, val, a;
        real           r;
        v = '0;
        s = (c_gsh >= DW) ? DW - 1 : c_gsh;
        for (int k = 0; k < LANES; k++) begin
            ph = (longint'(n * LANES + k) * c_inc) % (longint'(1) << PW);
            case (c_mode)
                0: begin
                    a = int'(ph >> (PW - AW));
                    r = 32767.0 * $sin(2.0 * PI * real'(a) / 512.0);
                    val = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
                end
                1: begin
                    val = int'(ph >> (PW - DW));
                    if (val >= 32768) val = val - 65536;
                end
                2: val = (n == 0 && k == 0) ? 32767 : 0;
                default: val = 32767;
            endcase
            val = val >>> s;
            v[k*DW +: DW] = val[DW-1:0];
        end
        return v;
    endfunction

    // One clock: drive at negedge, score any handshake, advance.
    task automatic step(input bit rdy, input bit st, input bit sp);
        out_ready = rdy;
        start     = st;
        stop      = sp;
        if (out_valid && rdy) begin
            chk("vec_count", vec_count, acc);
            chk($sformatf("data[%0d]", acc), data_out, exp_vec(acc));
            acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic begin_run(input int m, input longint inc,
                             input int g, input int b);
        c_mode     = m;
        c_inc      = inc;
        c_gsh      = g;
        mode       = 2'(m);
        phase_inc  = PW'(inc);
        gain_shift = 4'(g);
        burst_len  = 16'(b);
        acc        = 0;
        step(1'b1, 1'b1, 1'b0);
        mode       = 2'($urandom);
        phase_inc  = PW'($urandom);
        gain_shift = 4'($urandom);
        burst_len  = 16'($urandom);
    endtask

    task automatic drain();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (!busy) break;
            step(1'b1, 1'b0, 1'b0);
        end
        chk("drained", busy, 0);
        chk("drain_count", vec_count, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, g, b;
        longint inc;
        bit done;

        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vcount", vec_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Ramp: latency, backpressure, steady stream.
        begin_run(1, 'h100, 0, 0);
        chk("lat_valid0", out_valid, 0);
        chk("lat_busy", busy, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("lat_valid1", out_valid, 1);
        chk("ramp_v0", data_out, {16'd2, 16'd1, 16'd0});
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("stall_data", data_out, {16'd2, 16'd1, 16'd0});
            chk("stall_valid", out_valid, 1);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("ramp_v1", data_out, {16'd5, 16'd4, 16'd3});
        repeat (4) step(1'b1, 1'b0, 1'b0);
        chk("ramp_vcount", vec_count, 5);
        chk("ramp_v5", data_out, {16'd17, 16'd16, 16'd15});
        drain();

        // Sine quarter-turn steps across the phase wrap.
        begin_run(0, 'h400000, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("sine_v0", data_out, {16'd0, 16'd32767, 16'd0});
        step(1'b1, 1'b0, 1'b0);
        chk("sine_v1", data_out, {16'd32767, 16'd0, 16'h8001});
        repeat (4) step(1'b1, 1'b0, 1'b0);
        drain();

        // Impulse burst of four with gain 1.
        begin_run(2, 'h123, 1, 4);
        step(1'b1, 1'b0, 1'b0);
        chk("imp_v0", data_out, {16'd0, 16'd0, 16'd16383});
        repeat (4) step(1'b1, 1'b0, 1'b0);
        chk("imp_acc", acc, 4);
        chk("imp_busy", busy, 0);
        chk("imp_valid", out_valid, 0);
        chk("imp_vcount", vec_count, 4);
        step(1'b1, 1'b0, 1'b0);
        chk("imp_after", acc, 4);

        // Stop with a pending vector, then start+stop together.
        begin_run(1, 'h100, 0, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("stop_valid", out_valid, 1);
        chk("stop_busy", busy, 1);
        chk("stop_data", data_out, {16'd2, 16'd1, 16'd0});
        step(1'b0, 1'b0, 1'b0);
        chk("stop_hold", out_valid, 1);
        step(1'b1, 1'b0, 1'b0);
        chk("stop_drop", out_valid, 0);
        chk("stop_idle", busy, 0);
        chk("stop_vcount", vec_count, 1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("ss_valid", out_valid, 0);
        chk("ss_busy", busy, 0);

        // Asynchronous reset mid-run, then restart from phase 0.
        begin_run(1, 'h100, 0, 0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", data_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_vcount", vec_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        begin_run(1, 'h100, 0, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("arst_restart", data_out, {16'd2, 16'd1, 16'd0});
        drain();

        // Randomized runs under random backpressure.
        for (int it = 0; it < 14; it++) begin
            m   = int'($urandom_range(0, 3));
            inc = longint'($urandom) & ((longint'(1) << PW) - 1);
            g   = int'($urandom_range(0, 15));
            b   = (it % 2 == 0) ? 0 : int'($urandom_range(1, 6));
            begin_run(m, inc, g, b);
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                if (b != 0 && !busy) done = 1'b1;
                else if (b == 0 && c == 25) done = 1'b1;
                else step($urandom_range(0, 9) < 7, 1'b0, 1'b0);
            end
            if (b != 0) begin
                chk("burst_done", busy, 0);
                chk("burst_acc", acc, b);
                chk("burst_vcount", vec_count, b);
            end else begin
                drain();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
